// File: rtl/intarb.sv
// intarb: interrupt arbiter sharing one upstream request path among NREQ
// device request ports (1..8). One winner is chosen, its vector is offered
// upstream, and the processor grant is routed back to that winner only.
// Two ARM-readable status words: ID/version (armraddr=0) and live status
// (armraddr=1).
// Optional feature: define INTARB_RR_EN for round-robin priority; when it is
// undefined, the lowest asserted request index wins.
module intarb #(
    parameter int NREQ = 4
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              init_in_h,
    input  logic              armraddr,
    output logic [31:0]       armrdata,
    input  logic [NREQ-1:0]   dev_intreq,
    input  logic [8*NREQ-1:0] dev_irvec,
    output logic [NREQ-1:0]   dev_intgnt,
    output logic [7:0]        dev_igvec,
    output logic              intreq,
    output logic [7:0]        irvec,
    input  logic              intgnt,
    input  logic [7:0]        igvec
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] ARM_ID = 32'h4941_0001;

`ifdef INTARB_RR_EN
    localparam logic RR_FLAG = 1'b1;
`else
    localparam logic RR_FLAG = 1'b0;
`endif

    // Architectural state
    state_t      state_q, state_d;
    logic [2:0]  win_q, win_d;
    logic [7:0]  wvec_q, wvec_d;
    logic [15:0] grantcnt_q, grantcnt_d;
`ifdef INTARB_RR_EN
    logic [2:0]  last_win_q, last_win_d;
`endif

    // Next values of the registered outputs
    logic            intreq_d;
    logic [7:0]      irvec_d;
    logic [NREQ-1:0] gnt_d;
    logic [7:0]      igvec_d;
    logic [31:0]     arm_d;
    logic [31:0]     word1;

    // Request view padded to the full 8-port width
    logic [7:0]  pend;
    logic [63:0] vec_pad;

    // Arbitration result and per-cycle qualifiers
    logic [2:0] sel;
    logic       any_req;
    logic [7:0] sel_vec;
    logic       win_req;
    logic       grant_match;

    // Zero-extend request levels and vectors so indexing by a 3-bit winner
    // never reaches past the ports that exist.
    always_comb begin
        pend                = '0;
        pend[NREQ-1:0]      = dev_intreq;
        vec_pad             = '0;
        vec_pad[8*NREQ-1:0] = dev_irvec;
    end

    assign sel_vec     = vec_pad[{sel, 3'b000} +: 8];
    assign win_req     = pend[win_q];
    assign grant_match = intgnt && (igvec == wvec_q);

`ifdef INTARB_RR_EN
    // Round-robin search: start just after the last granted index and wrap.
    always_comb begin
        logic [3:0] idx;
        sel     = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            // last_win < NREQ and k < NREQ, so one subtraction wraps it.
            idx = {1'b0, last_win_q} + 4'd1 + 4'(k);
            if (idx >= 4'(NREQ)) begin
                idx = idx - 4'(NREQ);
            end
            if (!any_req && pend[idx[2:0]]) begin
                any_req = 1'b1;
                sel     = idx[2:0];
            end
        end
    end
`else
    // Fixed priority: scan from the top down so the lowest asserted index
    // is the last one written and therefore wins.
    always_comb begin
        sel     = '0;
        any_req = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                any_req = 1'b1;
                sel     = 3'(i);
            end
        end
    end
`endif

    // Next-state and output decode for the IDLE/OFFER/DRAIN handshake.
    // NOTE: every variable gets a default at the top of the block, so no
    // path through the case statement can leave one unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        wvec_d     = wvec_q;
        grantcnt_d = grantcnt_q;
        intreq_d   = intreq;
        irvec_d    = irvec;
        gnt_d      = '0;
        igvec_d    = dev_igvec;
`ifdef INTARB_RR_EN
        last_win_d = last_win_q;
`endif

        // NOTE: the synchronous RESET is folded into the next-state logic
        // rather than the register block, so the status word registered on
        // the same edge already reports the post-reset values.
        if (RESET || init_in_h) begin
            state_d  = IDLE;
            win_d    = '0;
            wvec_d   = '0;
            intreq_d = 1'b0;
            irvec_d  = '0;
            igvec_d  = '0;
`ifdef INTARB_RR_EN
            last_win_d = 3'(NREQ - 1);
`endif
            // INIT aborts arbitration but keeps the grant statistics.
            if (RESET) begin
                grantcnt_d = '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        win_d    = sel;
                        wvec_d   = sel_vec;
                        intreq_d = 1'b1;
                        irvec_d  = sel_vec;
                        state_d  = OFFER;
                    end else begin
                        intreq_d = 1'b0;
                    end
                end
                OFFER: begin
                    // A matching grant takes precedence over a withdraw
                    // seen in the same cycle.
                    if (grant_match) begin
                        for (int i = 0; i < NREQ; i++) begin
                            if (win_q == 3'(i)) begin
                                gnt_d[i] = 1'b1;
                            end
                        end
                        igvec_d    = igvec;
                        intreq_d   = 1'b0;
                        grantcnt_d = grantcnt_q + 16'd1;
                        state_d    = DRAIN;
`ifdef INTARB_RR_EN
                        last_win_d = win_q;
`endif
                    end else if (!win_req) begin
                        intreq_d = 1'b0;
                        state_d  = IDLE;
                    end
                end
                DRAIN: begin
                    // Hold off re-arbitration until the granted device lets
                    // go, so a still-asserted request is not granted twice.
                    if (!win_req) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    intreq_d = 1'b0;
                end
            endcase
        end
    end

    // Status word built from next-state values so it tracks the registers
    // it reports. Bit 7 flags the priority mode; with NREQ=8 it takes the
    // place of device 7's pending bit.
    always_comb begin
        word1    = {grantcnt_d, 2'b00, state_d, 1'b0, win_d, pend};
        word1[7] = RR_FLAG;
        arm_d    = armraddr ? word1 : ARM_ID;
    end

    // State and output registers.
    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, whatever order the simulator runs the blocks in.
    always_ff @(posedge CLOCK) begin
        state_q    <= state_d;
        win_q      <= win_d;
        wvec_q     <= wvec_d;
        grantcnt_q <= grantcnt_d;
`ifdef INTARB_RR_EN
        last_win_q <= last_win_d;
`endif
        intreq     <= intreq_d;
        irvec      <= irvec_d;
        dev_intgnt <= gnt_d;
        dev_igvec  <= igvec_d;
        armrdata   <= arm_d;
    end

endmodule

// File: tb/tb_intarb.sv
// tb_intarb: self-checking bench for intarb. Directed scenarios plus a
// randomized phase, all compared against a behavioural model of the
// arbitration rules kept in this file.
module tb_intarb;

    localparam int NREQ = 4;
    localparam int VW   = 8 * NREQ;
`ifdef INTARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            CLOCK = 1'b0;
    logic            RESET;
    logic            init_in_h;
    logic            armraddr;
    logic [31:0]     armrdata;
    logic [NREQ-1:0] dev_intreq;
    logic [VW-1:0]   dev_irvec;
    logic [NREQ-1:0] dev_intgnt;
    logic [7:0]      dev_igvec;
    logic            intreq;
    logic [7:0]      irvec;
    logic            intgnt;
    logic [7:0]      igvec;

    intarb #(.NREQ(NREQ)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .init_in_h  (init_in_h),
        .armraddr   (armraddr),
        .armrdata   (armrdata),
        .dev_intreq (dev_intreq),
        .dev_irvec  (dev_irvec),
        .dev_intgnt (dev_intgnt),
        .dev_igvec  (dev_igvec),
        .intreq     (intreq),
        .irvec      (irvec),
        .intgnt     (intgnt),
        .igvec      (igvec)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference model: 0 idle, 1 offering, 2 waiting for the winner to drop
    int              m_state;
    int              m_win;
    int              m_last;
    logic [7:0]      m_wvec;
    logic [7:0]      m_irvec;
    logic [7:0]      m_igvec;
    logic [15:0]     m_cnt;
    logic            m_intreq;
    logic [NREQ-1:0] m_gnt;
    logic [31:0]     m_arm;

    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit req_of(input logic [NREQ-1:0] req, input int i);
        logic [NREQ-1:0] sh;
        sh = req >> i;
        return sh[0];
    endfunction

    function automatic logic [7:0] vec_of(input logic [VW-1:0] vecs, input int i);
        logic [VW-1:0] sh;
        sh = vecs >> (8 * i);
        return sh[7:0];
    endfunction

    // Winner: first requester found scanning from 0 (fixed) or from the
    // index after the last granted one (round-robin).
    function automatic int pick(input logic [NREQ-1:0] req, input int last);
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = RR ? (last + 1 + k) % NREQ : k;
            if (req_of(req, idx)) return idx;
        end
        return 0;
    endfunction

    task automatic set_vec(input int i, input logic [7:0] v);
        logic [VW-1:0] m;
        m = VW'(8'hff);
        dev_irvec = (dev_irvec & ~(m << (8 * i))) | (VW'(v) << (8 * i));
    endtask

    task automatic model_step();
        m_gnt = '0;
        if (RESET || init_in_h) begin
            m_state  = 0;
            m_win    = 0;
            m_wvec   = '0;
            m_intreq = 1'b0;
            m_irvec  = '0;
            m_igvec  = '0;
            m_last   = NREQ - 1;
            if (RESET) m_cnt = '0;
        end else begin
            case (m_state)
                0: if (dev_intreq != '0) begin
                    m_win    = pick(dev_intreq, m_last);
                    m_wvec   = vec_of(dev_irvec, m_win);
                    m_intreq = 1'b1;
                    m_irvec  = m_wvec;
                    m_state  = 1;
                end
                1: if (intgnt && igvec == m_wvec) begin
                    m_gnt    = NREQ'(1) << m_win;
                    m_igvec  = igvec;
                    m_intreq = 1'b0;
                    m_cnt    = m_cnt + 16'd1;
                    m_last   = m_win;
                    m_state  = 2;
                end else if (!req_of(dev_intreq, m_win)) begin
                    m_intreq = 1'b0;
                    m_state  = 0;
                end
                default: if (!req_of(dev_intreq, m_win)) m_state = 0;
            endcase
        end
        m_arm = armraddr ? {m_cnt, 2'b00, 2'(m_state), 1'b0, 3'(m_win), RR, 7'(dev_intreq)}
                         : 32'h4941_0001;
    endtask

    task automatic compare();
        check("intreq", 32'(intreq), 32'(m_intreq));
        if (m_intreq) check("irvec", 32'(irvec), 32'(m_irvec));
        check("dev_intgnt", 32'(dev_intgnt), 32'(m_gnt));
        check("dev_igvec", 32'(dev_igvec), 32'(m_igvec));
        check("armrdata", armrdata, m_arm);
    endtask

    // One clock: model consumes the inputs the DUT sampled, then outputs are
    // compared 1 time unit after the edge.
    task automatic cycle();
        @(posedge CLOCK);
        model_step();
        #1;
        compare();
    endtask

    // Single grant to device 0: offer, matching grant with same-cycle drop,
    // then back to idle.
    task automatic quick_grant();
        dev_intreq = 4'b0001;
        cycle();
        intgnt = 1'b1;
        igvec  = 8'o100;
        dev_intreq = '0;
        cycle();
        intgnt = 1'b0;
        cycle();
    endtask

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        RESET      = 1'b1;
        init_in_h  = 1'b0;
        armraddr   = 1'b1;
        dev_intreq = '0;
        dev_irvec  = '0;
        intgnt     = 1'b0;
        igvec      = '0;
        m_state = 0; m_win = 0; m_last = NREQ - 1; m_wvec = '0; m_irvec = '0;
        m_igvec = '0; m_cnt = '0; m_intreq = 1'b0; m_gnt = '0; m_arm = '0;

        cycle();
        cycle();
        check("rst_word1", armrdata, {24'h0, RR, 7'h0});
        check("rst_intreq", 32'(intreq), 32'h0);
        RESET = 1'b0;

        // Single device: offer, grant, drain, idle
        set_vec(0, 8'o100);
        dev_intreq = 4'b0001;
        cycle();
        check("t1_intreq", 32'(intreq), 32'h1);
        check("t1_irvec", 32'(irvec), 32'(8'o100));
        intgnt = 1'b1;
        igvec  = 8'o100;
        cycle();
        check("t1_gnt", 32'(dev_intgnt), 32'h1);
        check("t1_igvec", 32'(dev_igvec), 32'(8'o100));
        check("t1_cnt", 32'(armrdata[31:16]), 32'h1);
        intgnt = 1'b0;
        cycle();
        check("t1_pulse", 32'(dev_intgnt), 32'h0);
        check("t1_drain", 32'(armrdata[13:12]), 32'h2);
        dev_intreq = '0;
        cycle();
        check("t1_idle", 32'(armrdata[13:12]), 32'h0);

        // Devices 1 and 3 together: 1 first, then 3
        set_vec(1, 8'o060);
        set_vec(3, 8'o300);
        dev_intreq = 4'b1010;
        cycle();
        check("t2_first", 32'(irvec), 32'(8'o060));
        intgnt = 1'b1;
        igvec  = 8'o060;
        cycle();
        check("t2_gnt1", 32'(dev_intgnt), 32'h2);
        intgnt = 1'b0;
        dev_intreq = 4'b1000;
        cycle();
        cycle();
        check("t2_second", 32'(irvec), 32'(8'o300));
        check("t2_intreq", 32'(intreq), 32'h1);
        intgnt = 1'b1;
        igvec  = 8'o300;
        cycle();
        check("t2_gnt3", 32'(dev_intgnt), 32'h8);
        intgnt = 1'b0;
        dev_intreq = '0;
        cycle();
        cycle();

        // Mismatched grant ignored, then withdraw without counting
        dev_intreq = 4'b0001;
        cycle();
        intgnt = 1'b1;
        igvec  = 8'o070;
        cycle();
        check("t3_nognt", 32'(dev_intgnt), 32'h0);
        check("t3_hold", 32'(intreq), 32'h1);
        intgnt = 1'b0;
        dev_intreq = '0;
        cycle();
        check("t3_withdraw", 32'(intreq), 32'h0);
        check("t3_idle", 32'(armrdata[13:12]), 32'h0);
        check("t3_cnt", 32'(armrdata[31:16]), 32'h3);

        // Grant and drop in the same cycle: grant wins
        dev_intreq = 4'b0001;
        cycle();
        intgnt = 1'b1;
        igvec  = 8'o100;
        dev_intreq = '0;
        cycle();
        check("t4_gnt", 32'(dev_intgnt), 32'h1);
        check("t4_cnt", 32'(armrdata[31:16]), 32'h4);
        check("t4_drain", 32'(armrdata[13:12]), 32'h2);
        intgnt = 1'b0;
        cycle();
        check("t4_idle", 32'(armrdata[13:12]), 32'h0);

        // INIT during an offer keeps the count; RESET clears it
        quick_grant();
        dev_intreq = 4'b0010;
        cycle();
        init_in_h = 1'b1;
        cycle();
        init_in_h = 1'b0;
        check("t5_intreq", 32'(intreq), 32'h0);
        check("t5_idle", 32'(armrdata[13:12]), 32'h0);
        check("t5_cnt", 32'(armrdata[31:16]), 32'h5);
        dev_intreq = '0;
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
        check("t5_rstcnt", 32'(armrdata[31:16]), 32'h0);

`ifdef INTARB_RR_EN
        // Both held: each winner drops for one cycle after its grant
        dev_intreq = 4'b1010;
        for (int g = 0; g < 4; g++) begin
            cycle();
            intgnt = 1'b1;
            igvec  = (g % 2 == 0) ? 8'o060 : 8'o300;
            cycle();
            check("rr_gnt", 32'(dev_intgnt), (g % 2 == 0) ? 32'h2 : 32'h8);
            intgnt = 1'b0;
            dev_intreq = (g % 2 == 0) ? 4'b1000 : 4'b0010;
            cycle();
            dev_intreq = 4'b1010;
        end
        dev_intreq = '0;
        cycle();
        cycle();
`endif

        // Counter wrap: preload close to the top, then grant across it
        force dut.grantcnt_q = 16'hfffd;
        m_cnt = 16'hfffd;
        cycle();
        release dut.grantcnt_q;
        check("t6_preload", 32'(armrdata[31:16]), 32'hfffd);
        for (int g = 0; g < 3; g++) quick_grant();
        check("t6_wrap", 32'(armrdata[31:16]), 32'h0);
        armraddr = 1'b0;
        cycle();
        check("t6_id", armrdata, 32'h4941_0001);

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) dev_intreq = NREQ'($urandom);
            if ($urandom_range(0, 7) == 0) set_vec(int'($urandom_range(0, NREQ - 1)), 8'($urandom));
            armraddr  = 1'($urandom_range(0, 1));
            init_in_h = ($urandom_range(0, 199) == 0);
            intgnt    = ($urandom_range(0, 2) == 0);
            igvec     = ($urandom_range(0, 3) == 0) ? 8'($urandom) : m_wvec;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/intarb.md
Name: intarb

Overview:
- Interrupt arbiter that shares the single upstream interrupt request path between up to 8 device interrupt sources (line clock, serial lines, disk, etc.).
- Each device's own request logic presents a request level and vector to this block. The block selects one winner and offers that winner's vector upstream. It routes the processor's grant back to the winner only.
- Sits between the per-device request logic and the processor/bus interrupt interface. Exposes two ARM-readable status words.

Parameters:
- NREQ, 4, number of device request ports (1..8).

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  synchronous, active-high reset; clock CLOCK
- init_in_h  in  1  bus INIT; aborts arbitration, does not clear counter
- armraddr  in  1  ARM read register select
- armrdata  out  32  ARM read data
- dev_intreq  in  NREQ  per-device request level
- dev_irvec  in  8*NREQ  per-device vector; device i at [8i+7:8i]
- dev_intgnt  out  NREQ  per-device grant pulse
- dev_igvec  out  8  granted vector, broadcast to all devices
- intreq  out  1  upstream request level
- irvec  out  8  upstream vector being offered
- intgnt  in  1  upstream grant pulse
- igvec  in  8  vector the upstream grant applies to

Behaviour:
- All outputs are registered. On RESET:
  - intreq=0, irvec=0, dev_intgnt=0, dev_igvec=0
  - state=IDLE, win=0, grantcnt=0
- init_in_h gives the same result as RESET, except grantcnt is held.
- States: IDLE(0), OFFER(1), DRAIN(2).
- IDLE:
  - If any dev_intreq bit is set, select winner index win (priority rule below).
  - Latch wvec = dev_irvec[win].
  - Register intreq<=1, irvec<=wvec, go OFFER. intreq is visible 1 clock after dev_intreq is sampled.
  - No request pending: stay IDLE, intreq=0.
- OFFER:
  - Grant match: intgnt=1 and igvec==wvec.
    - dev_intgnt[win]<=1 for exactly 1 clock, dev_igvec<=igvec.
    - intreq<=0, grantcnt<=grantcnt+1 (16 bit, wraps FFFF->0000), go DRAIN.
  - Grant mismatch: intgnt=1 and igvec!=wvec. Ignore it; stay OFFER.
  - Withdraw: dev_intreq[win]=0 with no matching grant. intreq<=0, go IDLE, no count.
  - Grant match and withdraw in the same cycle: the grant wins (pulse, count, DRAIN).
  - wvec stays latched for the whole offer, even if dev_irvec[win] changes mid-offer.
- DRAIN:
  - dev_intgnt=0.
  - Wait for dev_intreq[win]=0, then go IDLE. The next arbitration starts 1 clock later.
  - This stops the device whose request is still held high from being granted twice.
- Only one dev_intgnt bit is ever high, and only in the cycle after a matching grant.
- Fixed priority (default): the lowest asserted index wins.
- armrdata:
  - armraddr=0: 32'h49410001 ('IA', [15:12]=0 for 2 registers, version 001).
  - armraddr=1: {grantcnt[15:0], 2'b0, state[1:0], 1'b0, win[2:0], pend[7:0]}. pend = dev_intreq zero-extended to 8 bits.
- Ports above NREQ do not exist. NREQ=1 is a degenerate pass-through that still runs the FSM.

Optional Feature:
- Macro: INTARB_RR_EN.
- Defined: round-robin priority. The search starts at index (last_win+1) mod NREQ and wraps.
  - last_win is updated on each matching grant only; a withdraw does not update it.
  - last_win resets to NREQ-1, so the first search starts at index 0.
  - armrdata word1 bit 7 reads 1.
- Undefined: fixed priority, lowest index wins; word1 bit 7 reads 0.

Test Plan:
1. Reset, then dev_intreq=4'b0001 with vec0=8'o100 -> intreq=1 and irvec=8'o100 one clock later. intgnt with igvec=8'o100 -> dev_intgnt=0001 for 1 clock, dev_igvec=8'o100, grantcnt=1. Drop dev_intreq -> state returns to IDLE.
2. Devices 1 and 3 request simultaneously (vectors 8'o060 and 8'o300) -> 8'o060 is offered first; after its grant and drop, 8'o300 is offered. With INTARB_RR_EN, hold both requesting: grants alternate 1,3,1,3.
3. In OFFER, intgnt with igvec=8'o070 (mismatch) -> no dev_intgnt, intreq stays 1. Then device drops its request -> intreq=0, IDLE, grantcnt unchanged.
4. Matching grant and dev_intreq drop in the same cycle -> dev_intgnt pulses, grantcnt increments, state goes to DRAIN then IDLE.
5. init_in_h pulse during OFFER with grantcnt=5 -> intreq=0, state IDLE, grantcnt still 5. RESET -> grantcnt=0.
6. Preload grantcnt to FFFF via repeated grants; one more grant -> word1[31:16]=0000. armraddr=0 -> 32'h49410001.
